gearbox_tx_ctrl: RTL and testbench
==================================

Name: gearbox_tx_ctrl

Overview:
- Sits between the MAC/encoder and the 64b/66b TX gearbox.
- Absorbs the gearbox's 1-in-33 pause cycle with a 2-entry skid FIFO and applies backpressure to the MAC.
- Inserts 10GBASE-R idle blocks whenever the MAC has no block ready, and sends a fixed run of idles after reset before it accepts MAC traffic.
- Mirrors the gearbox sequence counter and flags a sticky error if the observed pause pattern diverges from the expected one.

Parameters:
- DATA_W, 64, block payload width; gearbox data width.
- HEAD_W, 2, sync header width.
- SEQ_W, $clog2(DATA_W/HEAD_W+1) = 6, width of the mirror sequence counter.
- INIT_IDLE_N, 4, number of idle blocks sent after reset before MAC traffic is accepted (at least 1).
- CNT_W, 16, width of the idle-insertion statistics counter.

Ports:
- clk  in  1  clock
- nreset  in  1  reset; asynchronous assert, active-low
- mac_valid_i  in  1  MAC block valid
- mac_ready_o  out  1  controller accepts a block this cycle
- mac_head_i  in  HEAD_W  MAC sync header
- mac_data_i  in  DATA_W  MAC block payload
- gb_accept_v_i  in  1  gearbox accept_v; low means the gearbox ignores its inputs this cycle
- gb_head_o  out  HEAD_W  header presented to the gearbox
- gb_data_o  out  DATA_W  payload presented to the gearbox
- idle_cnt_o  out  CNT_W  saturating count of inserted idle blocks
- sync_err_o  out  1  sticky error: pause-pattern mismatch

Behaviour:
- Reset (nreset low, asynchronous) clears the following:
  - FIFO is emptied.
  - FSM goes to INIT and the init counter to 0.
  - Mirror sequence counter (seq) goes to 0.
  - idle_cnt_o goes to 0 and sync_err_o to 0.
  - mac_ready_o is 0 during reset and in INIT.
- Idle block: gb_head_o=2'b10; gb_data_o = {56'h0, 8'h1E}, with the block type in data[7:0].
- gb_head_o and gb_data_o are combinational: the FIFO head when the FIFO is non-empty and the FSM is RUN, otherwise the idle block.
- Pop: a FIFO pop happens only when gb_accept_v_i=1, the FIFO is non-empty and the FSM is RUN.
- Idle insertion: an idle is counted in idle_cnt_o when gb_accept_v_i=1 and an idle is presented. idle_cnt_o saturates at all-ones.
- Push: a push happens when mac_valid_i and mac_ready_o are both 1.
  - mac_ready_o is registered: it is 1 in RUN when next-cycle occupancy is below 2.
  - A block accepted at cycle t appears on gb_data_o at t+1 at the earliest (zero-bubble path through an empty FIFO).
- Simultaneous push and pop on a full FIFO is not possible, because ready is already 0.
- Simultaneous push and pop at occupancy 1 leaves occupancy at 1 and preserves order.
- Pause cycle (gb_accept_v_i=0): nothing pops, the outputs are held unchanged, and the idle counter does not increment.
- FSM:
  - INIT: counts accepted idle cycles (gb_accept_v_i=1). After INIT_IDLE_N accepted idles it moves to RUN. mac_ready_o rises on the cycle after the transition.
  - RUN: normal operation. It only leaves RUN on reset.
- Mirror sequence counter:
  - seq counts 0..32 and advances every cycle. When seq=32, the next value is 0.
  - The gearbox is expected to have gb_accept_v_i=0 exactly when seq=32, and 1 otherwise.
  - Any mismatch sets sync_err_o=1, and it stays set until reset.
  - Both counters come out of reset together, so cycle 0 after reset is seq=0.
- Reset during operation: in-flight FIFO contents are discarded, and the sequence restarts with INIT.

Decomposition:
- Package gearbox_pkg holds:
  - the idle block constants IDLE_HEAD = 2'b10 and IDLE_DATA = {56'h0, 8'h1E};
  - the sync header constants CTRL_HEAD = 2'b10 and DATA_HEAD = 2'b01;
  - the FSM state enum {INIT, RUN};
  - the pause period constant PAUSE_SEQ = DATA_W/HEAD_W (32).
- One sub-module, gearbox_skid_fifo: 2-entry, width HEAD_W+DATA_W, with push/pop, empty/full and registered almost-full, and asynchronous active-low reset.

Test Plan:
- Reset release, mac_valid_i=0, gearbox model pausing at seq 32 -> first 4 accepted cycles show the idle block (head 2'b10, data 64'h1E); mac_ready_o rises on the cycle after the 4th accepted idle; sync_err_o stays 0.
- In RUN, stream 100 back-to-back blocks (data = index, head 2'b01) through the 32-accept/1-pause gearbox -> all 100 blocks emerge in order with no loss or duplication; mac_ready_o drops for at most 1 cycle per pause; idle_cnt_o increments only in gaps.
- Push on the pause cycle while 1 entry is queued -> FIFO reaches 2, mac_ready_o=0 on the next cycle, and both blocks emerge on the 2 following accept cycles.
- Inject gb_accept_v_i=0 at seq=10 -> sync_err_o=1 from the next cycle and held; data flow is otherwise unaffected; a later reset clears it.
- Force idle_cnt_o near saturation (CNT_W=4 build, 20 idle cycles) -> the counter holds at 4'hF.
- Assert nreset low mid-stream with 2 entries queued -> the outputs show the idle block immediately, and after release the INIT sequence repeats with the old entries discarded.

Source files
------------

// File: rtl/gearbox_pkg.sv
// Shared constants and types for the 64b/66b TX gearbox controller.
// Idle block encoding, sync headers, FSM states and the gearbox pause period.
package gearbox_pkg;

  localparam int GB_DATA_W = 64;
  localparam int GB_HEAD_W = 2;
  localparam int PAUSE_SEQ = GB_DATA_W / GB_HEAD_W;

  localparam logic [1:0]  CTRL_HEAD = 2'b10;
  localparam logic [1:0]  DATA_HEAD = 2'b01;
  localparam logic [1:0]  IDLE_HEAD = CTRL_HEAD;
  localparam logic [63:0] IDLE_DATA = {56'h0, 8'h1E};

  typedef enum logic {
    INIT,
    RUN
  } gb_state_e;

endpackage

// File: rtl/gearbox_skid_fifo.sv
// Two-entry skid FIFO that rides out gearbox pause cycles.
// Push is ignored when full and pop is ignored when empty.
module gearbox_skid_fifo #(
  parameter int W = 66
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic         almost_full
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;
  logic [1:0]   cnt_d;
  logic         af_q;
  logic         do_push;
  logic         do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    cnt_d = cnt;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt + 2'd1;
      2'b01:   cnt_d = cnt - 2'd1;
      default: cnt_d = cnt;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= '0;
      af_q   <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop)
        rd_ptr <= ~rd_ptr;
      cnt  <= cnt_d;
      // almost_full means exactly one slot left
      af_q <= (cnt_d == 2'd1);
    end
  end

  assign dout        = mem[rd_ptr];
  assign empty       = (cnt == 2'd0);
  assign full        = (cnt == 2'd2);
  assign almost_full = af_q;

endmodule

// File: rtl/gearbox_tx_ctrl.sv
// TX controller between the MAC and the 64b/66b gearbox: skid buffering,
// idle insertion, post-reset idle run and pause-pattern supervision.
module gearbox_tx_ctrl
  import gearbox_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int HEAD_W      = 2,
  parameter int SEQ_W       = $clog2(DATA_W / HEAD_W + 1),
  parameter int INIT_IDLE_N = 4,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              mac_valid_i,
  output logic              mac_ready_o,
  input  logic [HEAD_W-1:0] mac_head_i,
  input  logic [DATA_W-1:0] mac_data_i,
  input  logic              gb_accept_v_i,
  output logic [HEAD_W-1:0] gb_head_o,
  output logic [DATA_W-1:0] gb_data_o,
  output logic [CNT_W-1:0]  idle_cnt_o,
  output logic              sync_err_o
);

  localparam int INIT_W = $clog2(INIT_IDLE_N + 1);
  localparam logic [SEQ_W-1:0]  PAUSE  = SEQ_W'(PAUSE_SEQ);
  localparam logic [HEAD_W-1:0] IDLE_H = HEAD_W'(IDLE_HEAD);
  localparam logic [DATA_W-1:0] IDLE_D = DATA_W'(IDLE_DATA);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_IDLE_N - 1);

  gb_state_e          state, state_d;
  logic [INIT_W-1:0]  init_cnt, init_cnt_d;
  logic [SEQ_W-1:0]   seq;
  logic [CNT_W-1:0]   idle_cnt;
  logic               sync_err;
  logic               ready_q;
  logic               ready_d;

  logic [HEAD_W+DATA_W-1:0] fifo_dout;
  logic                     fifo_empty;
  logic                     fifo_full;
  logic                     fifo_afull;
  logic                     push;
  logic                     pop;
  logic                     show_fifo;
  logic                     accept_idle;
  logic                     full_next;
  logic                     exp_accept;

  gearbox_skid_fifo #(
    .W(HEAD_W + DATA_W)
  ) u_fifo (
    .clk         (clk),
    .nreset      (nreset),
    .push        (push),
    .pop         (pop),
    .din         ({mac_head_i, mac_data_i}),
    .dout        (fifo_dout),
    .empty       (fifo_empty),
    .full        (fifo_full),
    .almost_full (fifo_afull)
  );

  assign show_fifo   = (state == RUN) & ~fifo_empty;
  assign pop         = gb_accept_v_i & show_fifo;
  assign push        = mac_valid_i & ready_q;
  assign accept_idle = gb_accept_v_i & ~show_fifo;

  assign gb_head_o = show_fifo ? fifo_dout[HEAD_W+DATA_W-1:DATA_W] : IDLE_H;
  assign gb_data_o = show_fifo ? fifo_dout[DATA_W-1:0] : IDLE_D;

  always_comb begin
    state_d    = state;
    init_cnt_d = init_cnt;
    unique case (state)
      INIT: begin
        if (gb_accept_v_i) begin
          if (init_cnt == INIT_LAST)
            state_d = RUN;
          else
            init_cnt_d = init_cnt + 1'b1;
        end
      end
      RUN: state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // Ready is registered, so look ahead at the occupancy after this edge.
  assign full_next  = (fifo_full & ~pop) | (fifo_afull & push & ~pop);
  assign ready_d    = (state_d == RUN) & ~full_next;
  assign exp_accept = (seq != PAUSE);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state    <= INIT;
      init_cnt <= '0;
      seq      <= '0;
      idle_cnt <= '0;
      sync_err <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state    <= state_d;
      init_cnt <= init_cnt_d;
      seq      <= (seq == PAUSE) ? '0 : seq + 1'b1;
      if (accept_idle && (idle_cnt != '1))
        idle_cnt <= idle_cnt + 1'b1;
      sync_err <= sync_err | (gb_accept_v_i != exp_accept);
      ready_q  <= ready_d;
    end
  end

  assign mac_ready_o = ready_q;
  assign idle_cnt_o  = idle_cnt;
  assign sync_err_o  = sync_err;

endmodule

// File: tb/tb_gearbox_tx_ctrl.sv
// Directed bench for gearbox_tx_ctrl: INIT idles, streaming through pauses,
// pause-pattern error, counter saturation (CNT_W=4 copy) and mid-stream reset.
module tb_gearbox_tx_ctrl;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        mac_valid = 1'b0;
  logic [1:0]  mac_head = 2'b01;
  logic [63:0] mac_data = '0;
  logic        gb_accept_v = 1'b1;
  logic        mac_ready, mac_ready_s;
  logic [1:0]  gb_head, gb_head_s;
  logic [63:0] gb_data, gb_data_s;
  logic [15:0] idle_cnt;
  logic [3:0]  idle_cnt_s;
  logic        sync_err, sync_err_s;

  int checks = 0;
  int errors = 0;
  int tseq = 0;
  int pushed;
  int rcv;

  always #5 clk = ~clk;

  gearbox_tx_ctrl u_dut (
    .clk           (clk),
    .nreset        (nreset),
    .mac_valid_i   (mac_valid),
    .mac_ready_o   (mac_ready),
    .mac_head_i    (mac_head),
    .mac_data_i    (mac_data),
    .gb_accept_v_i (gb_accept_v),
    .gb_head_o     (gb_head),
    .gb_data_o     (gb_data),
    .idle_cnt_o    (idle_cnt),
    .sync_err_o    (sync_err)
  );

  gearbox_tx_ctrl #(
    .CNT_W(4)
  ) u_dut_small (
    .clk           (clk),
    .nreset        (nreset),
    .mac_valid_i   (mac_valid),
    .mac_ready_o   (mac_ready_s),
    .mac_head_i    (mac_head),
    .mac_data_i    (mac_data),
    .gb_accept_v_i (gb_accept_v),
    .gb_head_o     (gb_head_s),
    .gb_data_o     (gb_data_s),
    .idle_cnt_o    (idle_cnt_s),
    .sync_err_o    (sync_err_s)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    tseq = (tseq == 32) ? 0 : tseq + 1;
    gb_accept_v = (tseq != 32);
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    mac_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nreset = 1'b1;
    tseq = 0;
    gb_accept_v = 1'b1;
  endtask

  initial begin
    // Phase A: post-reset idle run, then 100 back-to-back blocks
    do_reset();
    for (int c = 0; c < 4; c++) begin
      mac_valid = 1'b0;
      @(negedge clk);
      check("init_head", gb_head, 2'b10);
      check("init_data", gb_data, 64'h1E);
      check("init_ready", mac_ready, 1'b0);
      tick();
    end
    pushed = 0;
    rcv = 0;
    for (int cyc = 0; cyc < 400 && rcv < 100; cyc++) begin
      mac_valid = (pushed < 100);
      mac_head  = 2'b01;
      mac_data  = 64'(pushed);
      @(negedge clk);
      if (cyc == 0) begin
        check("run_ready_rise", mac_ready, 1'b1);
        check("init_idle_cnt", idle_cnt, 64'd4);
      end
      if (pushed < 100)
        check("stream_ready", mac_ready, (tseq != 0));
      if (gb_accept_v && gb_head == 2'b01) begin
        check("stream_data", gb_data, 64'(rcv));
        if (rcv == 99)
          check("stream_idle_cnt", idle_cnt, 64'd5);
        rcv++;
      end
      if (mac_valid && mac_ready)
        pushed++;
      tick();
    end
    mac_valid = 1'b0;
    check("stream_count", 64'(rcv), 64'd100);
    check("stream_sync_err", sync_err, 1'b0);

    // Phase B: unexpected pause at seq 10, sticky error, saturation
    do_reset();
    for (int cyc = 0; cyc <= 25; cyc++) begin
      if (tseq == 10) gb_accept_v = 1'b0;
      mac_valid = (cyc == 11);
      mac_head  = 2'b01;
      mac_data  = 64'hABCD;
      @(negedge clk);
      if (cyc == 10) begin
        check("err_before", sync_err, 1'b0);
        check("cnt_at10", idle_cnt, 64'd10);
      end
      if (cyc == 11) begin
        check("err_set", sync_err, 1'b1);
        check("cnt_pause_hold", idle_cnt, 64'd10);
        check("ready_after_err", mac_ready, 1'b1);
      end
      if (cyc == 12) begin
        check("err_data_head", gb_head, 2'b01);
        check("err_data", gb_data, 64'hABCD);
        check("cnt_data_cycle", idle_cnt, 64'd11);
      end
      if (cyc == 16) check("sat_e", idle_cnt_s, 64'hE);
      if (cyc == 17) check("sat_f", idle_cnt_s, 64'hF);
      if (cyc == 25) begin
        check("sat_hold", idle_cnt_s, 64'hF);
        check("cnt_wide", idle_cnt, 64'd23);
        check("err_sticky", sync_err, 1'b1);
      end
      tick();
    end
    mac_valid = 1'b0;
    do_reset();
    @(negedge clk);
    check("err_cleared", sync_err, 1'b0);
    check("cnt_cleared", idle_cnt, 64'd0);

    // Phase C: continuing from that reset, fill both entries, then reset mid-stream
    for (int cyc = 1; cyc <= 33; cyc++) begin
      tick();
      mac_valid = 1'b1;
      mac_head  = 2'b01;
      mac_data  = 64'(cyc);
      @(negedge clk);
      if (cyc < 4) check("c_init_ready", mac_ready, 1'b0);
      if (cyc == 33) begin
        check("full_ready_low", mac_ready, 1'b0);
        check("full_head", gb_head, 2'b01);
        check("full_data", gb_data, 64'd31);
      end
    end
    mac_valid = 1'b0;
    nreset = 1'b0;
    #1;
    check("rst_head", gb_head, 2'b10);
    check("rst_data", gb_data, 64'h1E);
    check("rst_ready", mac_ready, 1'b0);
    check("rst_cnt", idle_cnt, 64'd0);
    @(posedge clk);
    #1;
    nreset = 1'b1;
    tseq = 0;
    gb_accept_v = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      check("re_head", gb_head, 2'b10);
      check("re_data", gb_data, 64'h1E);
      check("re_ready", mac_ready, (c == 4));
      if (c == 4) check("re_cnt", idle_cnt, 64'd4);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
